// File: rtl/ps2_mouse_pkg.sv
// Shared encodings, status-bit positions and payload types for the PS/2 mouse tracker.
package ps2_mouse_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DELTA_W = 9;
    localparam int unsigned WHEEL_W = 4;
    localparam int unsigned BTN_W   = 3;
    localparam int unsigned ERR_W   = 8;

    localparam int unsigned BTN_L   = 0;
    localparam int unsigned BTN_R   = 1;
    localparam int unsigned BTN_M   = 2;
    localparam int unsigned ALWAYS1 = 3;
    localparam int unsigned XSIGN   = 4;
    localparam int unsigned YSIGN   = 5;
    localparam int unsigned XOVF    = 6;
    localparam int unsigned YOVF    = 7;

    localparam logic signed [DELTA_W-1:0] DELTA_POS_SAT = 9'sh0FF;
    localparam logic signed [DELTA_W-1:0] DELTA_NEG_SAT = 9'sh100;

    typedef enum logic [1:0] {
        S_B0 = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2,
        S_B3 = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] status;
        logic [BYTE_W-1:0] x;
        logic [BYTE_W-1:0] y;
    } ps2_pkt_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/ps2_mouse_tracker_if.sv
// Byte-stream input and decoded-packet output bundle of the PS/2 mouse tracker.
interface ps2_mouse_tracker_if
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned POS_W = 10
) ();

    logic [BYTE_W-1:0]  rx_data;
    logic               rx_ready;
    logic               rx_error;
    logic               enable;
    logic               wheel_mode;

    logic [POS_W-1:0]   pos_x;
    logic [POS_W-1:0]   pos_y;
    logic [DELTA_W-1:0] mouse_dx;
    logic [DELTA_W-1:0] mouse_dy;
    logic [WHEEL_W-1:0] wheel_dz;
    logic [BTN_W-1:0]   buttons;
    logic               packet_ready;
    logic [ERR_W-1:0]   sync_err_cnt;

    modport master (
        output rx_data, rx_ready, rx_error, enable, wheel_mode,
        input  pos_x, pos_y, mouse_dx, mouse_dy, wheel_dz, buttons,
               packet_ready, sync_err_cnt
    );

    modport slave (
        input  rx_data, rx_ready, rx_error, enable, wheel_mode,
        output pos_x, pos_y, mouse_dx, mouse_dy, wheel_dz, buttons,
               packet_ready, sync_err_cnt
    );

endinterface

// File: rtl/ps2_axis_accum.sv
// One cursor axis: overflow-saturated delta, signed add or subtract, clamp to 0..RANGE-1.
module ps2_axis_accum
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned RANGE    = 640,
    parameter int unsigned POS_W    = 10,
    parameter bit          SUBTRACT = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               commit_i,
    input  logic               sign_i,
    input  logic               ovf_i,
    input  logic [BYTE_W-1:0]  mag_i,
    output logic [POS_W-1:0]   pos_o,
    output logic [DELTA_W-1:0] delta_o
);

    localparam int unsigned SUM_W = POS_W + 2;
    localparam logic [POS_W-1:0]        POS_RST = POS_W'(RANGE / 2);
    localparam logic [POS_W-1:0]        POS_TOP = POS_W'(RANGE - 1);
    localparam logic signed [SUM_W-1:0] POS_MAX = SUM_W'(RANGE - 1);

    logic signed [DELTA_W-1:0] delta_c;
    logic signed [SUM_W-1:0]   base_c;
    logic signed [SUM_W-1:0]   step_c;
    logic signed [SUM_W-1:0]   sum_c;
    logic [POS_W-1:0]          pos_d;
    logic [POS_W-1:0]          pos_q;
    logic [DELTA_W-1:0]        delta_q;

    // Sign bit of the sum catches underflow; the upper bound is compared signed.
    always_comb begin
        delta_c = signed'({sign_i, mag_i});
        if (ovf_i) begin
            delta_c = sign_i ? DELTA_NEG_SAT : DELTA_POS_SAT;
        end
        base_c = signed'({2'b00, pos_q});
        step_c = SUM_W'(delta_c);
        sum_c  = SUBTRACT ? (base_c - step_c) : (base_c + step_c);
        if (sum_c[SUM_W-1]) begin
            pos_d = '0;
        end else if (sum_c > POS_MAX) begin
            pos_d = POS_TOP;
        end else begin
            pos_d = sum_c[POS_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q   <= POS_RST;
            delta_q <= '0;
        end else if (commit_i) begin
            pos_q   <= pos_d;
            delta_q <= delta_c;
        end
    end

    assign pos_o   = pos_q;
    assign delta_o = delta_q;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet framer and clamped cursor tracker.
// Define PS2_WHEEL_EN to build in 4-byte IntelliMouse packets selected by wheel_mode.
module ps2_mouse_tracker
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned POS_W      = 10,
    parameter int unsigned CLK_HZ     = 27_000_000,
    parameter int unsigned TIMEOUT_US = 2000
) (
    input  logic          clk,
    input  logic          rst_n,
    ps2_mouse_tracker_if.slave bus
);

    localparam int unsigned TIMEOUT_CYC = (CLK_HZ / 1_000_000) * TIMEOUT_US;
    localparam int unsigned CNT_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    ps2_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    ps2_pkt_t            pkt_q, pkt_d;
    logic                pkt4_q, pkt4_d;
    logic                commit_c;
    logic                drop_c;
    logic                wheel_sel_c;
    logic [BYTE_W-1:0]   commit_y_c;

    logic [ERR_W-1:0]    err_q;
    logic [BTN_W-1:0]    btn_q;
    logic                pr_q;

`ifdef PS2_WHEEL_EN
    logic unused_c;
    assign wheel_sel_c = bus.wheel_mode;
    assign unused_c    = pkt_q.status[ALWAYS1];
`else
    logic unused_c;
    assign wheel_sel_c = 1'b0;
    assign unused_c    = ^{pkt_q.status[ALWAYS1], bus.wheel_mode};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_B0;
            cnt_q   <= '0;
            pkt_q   <= '0;
            pkt4_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pkt_q   <= pkt_d;
            pkt4_q  <= pkt4_d;
        end
    end

    // Priority: disable, then rx_error, then an accepted byte, then the inter-byte timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pkt_d    = pkt_q;
        pkt4_d   = pkt4_q;
        commit_c = 1'b0;
        drop_c   = 1'b0;

        if (!bus.enable) begin
            state_d = S_B0;
            cnt_d   = '0;
        end else if (bus.rx_error) begin
            drop_c  = (state_q != S_B0);
            state_d = S_B0;
            cnt_d   = '0;
        end else if (bus.rx_ready) begin
            cnt_d = '0;
            case (state_q)
                S_B0: begin
                    if (bus.rx_data[ALWAYS1]) begin
                        pkt_d.status = bus.rx_data;
                        pkt4_d       = wheel_sel_c;
                        state_d      = S_B1;
                    end else begin
                        drop_c = 1'b1;
                    end
                end
                S_B1: begin
                    pkt_d.x = bus.rx_data;
                    state_d = S_B2;
                end
                S_B2: begin
                    pkt_d.y = bus.rx_data;
                    if (pkt4_q) begin
                        state_d = S_B3;
                    end else begin
                        commit_c = 1'b1;
                        state_d  = S_B0;
                    end
                end
                S_B3: begin
                    commit_c = 1'b1;
                    state_d  = S_B0;
                end
                default: state_d = S_B0;
            endcase
        end else if (state_q != S_B0) begin
            if (cnt_q == TIMEOUT_LAST) begin
                drop_c  = 1'b1;
                state_d = S_B0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // A 3-byte commit happens on the Y byte itself, so take Y straight from the receiver.
    assign commit_y_c = (state_q == S_B3) ? pkt_q.y : bus.rx_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
            btn_q <= '0;
            pr_q  <= 1'b0;
        end else begin
            pr_q <= commit_c;
            if (drop_c) begin
                err_q <= sat_inc(err_q);
            end
            if (commit_c) begin
                btn_q <= {pkt_q.status[BTN_M], pkt_q.status[BTN_R], pkt_q.status[BTN_L]};
            end
        end
    end

`ifdef PS2_WHEEL_EN
    logic [WHEEL_W-1:0] dz_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dz_q <= '0;
        end else if (commit_c) begin
            dz_q <= (state_q == S_B3) ? bus.rx_data[WHEEL_W-1:0] : '0;
        end
    end

    assign bus.wheel_dz = dz_q;
`else
    assign bus.wheel_dz = '0;
`endif

    ps2_axis_accum #(
        .RANGE    (SCREEN_W),
        .POS_W    (POS_W),
        .SUBTRACT (1'b0)
    ) u_acc_x (
        .clk      (clk),
        .rst_n    (rst_n),
        .commit_i (commit_c),
        .sign_i   (pkt_q.status[XSIGN]),
        .ovf_i    (pkt_q.status[XOVF]),
        .mag_i    (pkt_q.x),
        .pos_o    (bus.pos_x),
        .delta_o  (bus.mouse_dx)
    );

    // PS/2 +Y points up while screen +Y points down.
    ps2_axis_accum #(
        .RANGE    (SCREEN_H),
        .POS_W    (POS_W),
        .SUBTRACT (1'b1)
    ) u_acc_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .commit_i (commit_c),
        .sign_i   (pkt_q.status[YSIGN]),
        .ovf_i    (pkt_q.status[YOVF]),
        .mag_i    (commit_y_c),
        .pos_o    (bus.pos_y),
        .delta_o  (bus.mouse_dy)
    );

    assign bus.buttons      = btn_q;
    assign bus.packet_ready = pr_q;
    assign bus.sync_err_cnt = err_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Self-checking bench for ps2_mouse_tracker against a packet-level reference model.
module tb_ps2_mouse_tracker;
    import ps2_mouse_pkg::*;

    localparam int unsigned SW     = 640;
    localparam int unsigned SH     = 480;
    localparam int unsigned PW     = 10;
    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned TUS    = 40;
    localparam int          T      = 40;
`ifdef PS2_WHEEL_EN
    localparam bit HAS_WHEEL = 1'b1;
`else
    localparam bit HAS_WHEEL = 1'b0;
`endif

    typedef struct packed {
        logic [PW-1:0] px;
        logic [PW-1:0] py;
        logic [8:0]    dx;
        logic [8:0]    dy;
        logic [2:0]    btn;
        logic [3:0]    dz;
        logic          pr;
        logic [7:0]    err;
    } snap_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   pr_cnt = 0;

    int         mx, my, merr;
    logic [8:0] mdx, mdy;
    logic [2:0] mbtn;
    logic [3:0] mdz;

    ps2_mouse_tracker_if #(.POS_W(PW)) bus ();

    ps2_mouse_tracker #(
        .SCREEN_W   (SW),
        .SCREEN_H   (SH),
        .POS_W      (PW),
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TUS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (bus.packet_ready === 1'b1) pr_cnt++;
    end

    // ---------------- reference model ----------------
    function automatic int ax_delta(input bit sgn, input bit ovf, input logic [7:0] m);
        if (ovf) return sgn ? -256 : 255;
        return sgn ? int'(m) - 256 : int'(m);
    endfunction

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        mx = int'(SW / 2); my = int'(SH / 2); merr = 0;
        mdx = '0; mdy = '0; mbtn = '0; mdz = '0;
    endtask

    task automatic model_commit(input logic [7:0] st, input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] z, input bit four);
        int dx, dy;
        dx = ax_delta(st[4], st[6], x);
        dy = ax_delta(st[5], st[7], y);
        mx = clampi(mx + dx, int'(SW) - 1);
        my = clampi(my - dy, int'(SH) - 1);
        mdx = 9'(dx); mdy = 9'(dy); mbtn = st[2:0];
        mdz = four ? z[3:0] : 4'h0;
    endtask

    task automatic model_drop();
        merr = (merr < 255) ? merr + 1 : 255;
    endtask

    function automatic snap_t expect_snap(input bit pr);
        snap_t s;
        s.px = PW'(mx); s.py = PW'(my); s.dx = mdx; s.dy = mdy;
        s.btn = mbtn; s.dz = mdz; s.pr = pr; s.err = 8'(merr);
        return s;
    endfunction

    function automatic snap_t observe();
        snap_t s;
        s.px = bus.pos_x; s.py = bus.pos_y; s.dx = bus.mouse_dx; s.dy = bus.mouse_dy;
        s.btn = bus.buttons; s.dz = bus.wheel_dz; s.pr = bus.packet_ready; s.err = bus.sync_err_cnt;
        return s;
    endfunction

    function automatic string show(input snap_t s);
        return $sformatf("pos=(%0d,%0d) d=(%0d,%0d) btn=%b dz=%h pr=%b err=%0d",
                         s.px, s.py, $signed(s.dx), $signed(s.dy), s.btn, s.dz, s.pr, s.err);
    endfunction

    // ---------------- stimulus ----------------
    // Called at a negedge; strobes one byte across exactly one posedge, then idles.
    task automatic put(input logic [7:0] b, input int idle, input bit err = 1'b0);
        bus.rx_data = b; bus.rx_ready = 1'b1; bus.rx_error = err;
        @(negedge clk);
        bus.rx_ready = 1'b0; bus.rx_error = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] st, input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] z, input int gap);
        bit four;
        four = HAS_WHEEL && bus.wheel_mode;
        put(st, gap);
        put(x, gap);
        if (four) begin
            put(y, gap);
            put(z, 0);
        end else begin
            put(y, 0);
        end
        model_commit(st, x, y, z, four);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.rx_ready = 1'b0; bus.rx_error = 1'b0; bus.rx_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        snap_t got, exp;
        do_reset();
        got = observe(); exp = expect_snap(1'b0); tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_state: got %s exp %s", show(got), show(exp)); end
        send_pkt(8'h08, 8'h30, 8'h30, 8'h00, 1);
        put(8'h08, 0); put(8'h05, 0);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        got = observe(); exp = expect_snap(1'b0); tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_midpkt: got %s exp %s", show(got), show(exp)); end
        rst_n = 1'b1;
        send_pkt(8'h08, 8'h0A, 8'h0A, 8'h00, 1);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_reframe: got %s exp %s", show(got), show(exp)); end
    endtask

    task automatic test_basic();
        snap_t got, exp;
        int p0;
        do_reset();
        p0 = pr_cnt;
        send_pkt(8'h08, 8'h05, 8'h05, 8'h00, 2);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp) begin fails++; $display("FAIL basic_pos: got %s exp %s", show(got), show(exp)); end
        @(negedge clk);
        got = observe(); exp = expect_snap(1'b0); tests++;
        if (got !== exp || pr_cnt != p0 + 1) begin
            fails++; $display("FAIL basic_pulse: got %s pulses=%0d exp %s pulses=%0d", show(got), pr_cnt - p0, show(exp), 1);
        end
        do_reset();
        send_pkt(8'h3F, 8'hF9, 8'hF9, 8'h00, 0);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp) begin fails++; $display("FAIL basic_neg: got %s exp %s", show(got), show(exp)); end
    endtask

    task automatic test_clamp();
        snap_t got, exp;
        do_reset();
        for (int i = 0; i < 10; i++) send_pkt(8'h08, 8'h32, 8'h00, 8'h00, 1);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp) begin fails++; $display("FAIL clamp_xmax: got %s exp %s", show(got), show(exp)); end
        send_pkt(8'h18, 8'hCE, 8'h00, 8'h00, 1);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp) begin fails++; $display("FAIL clamp_xback: got %s exp %s", show(got), show(exp)); end
        for (int i = 0; i < 3; i++) send_pkt(8'h08, 8'h00, 8'h7F, 8'h00, 0);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp) begin fails++; $display("FAIL clamp_ymin: got %s exp %s", show(got), show(exp)); end
        send_pkt(8'hF8, 8'h12, 8'h34, 8'h00, 0);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp) begin fails++; $display("FAIL clamp_ovf_neg: got %s exp %s", show(got), show(exp)); end
        send_pkt(8'hC8, 8'h00, 8'h00, 8'h00, 0);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp) begin fails++; $display("FAIL clamp_ovf_pos: got %s exp %s", show(got), show(exp)); end
    endtask

    task automatic test_resync();
        snap_t got, exp;
        do_reset();
        put(8'h00, 1);
        model_drop();
        send_pkt(8'h09, 8'h0A, 8'h0A, 8'h00, 1);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp) begin fails++; $display("FAIL resync: got %s exp %s", show(got), show(exp)); end
    endtask

    task automatic test_timeout();
        snap_t got, exp;
        int p0;
        do_reset();
        p0 = pr_cnt;
        put(8'h08, 0); put(8'h05, T + 10);
        model_drop();
        send_pkt(8'h08, 8'h0A, 8'h0A, 8'h00, 1);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp || pr_cnt != p0 + 1) begin
            fails++; $display("FAIL timeout_drop: got %s pulses=%0d exp %s pulses=%0d", show(got), pr_cnt - p0, show(exp), 1);
        end
        put(8'h08, T - 1);
        tests++;
        if (bus.sync_err_cnt !== 8'(merr)) begin
            fails++; $display("FAIL timeout_early: got err=%0d exp err=%0d", bus.sync_err_cnt, merr);
        end
        @(negedge clk);
        model_drop();
        tests++;
        if (bus.sync_err_cnt !== 8'(merr)) begin
            fails++; $display("FAIL timeout_edge: got err=%0d exp err=%0d", bus.sync_err_cnt, merr);
        end
        put(8'h08, T - 1); put(8'h0A, T - 1); put(8'hF3, 0);
        model_commit(8'h08, 8'h0A, 8'hF3, 8'h00, 1'b0);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp) begin fails++; $display("FAIL timeout_limit_ok: got %s exp %s", show(got), show(exp)); end
    endtask

    task automatic test_error();
        snap_t got, exp;
        int p0;
        do_reset();
        p0 = pr_cnt;
        put(8'h08, 0); put(8'h01, 0); put(8'h01, 1, 1'b1);
        model_drop();
        tests++;
        if (bus.sync_err_cnt !== 8'(merr) || pr_cnt != p0) begin
            fails++; $display("FAIL err_with_byte: got err=%0d pulses=%0d exp err=%0d pulses=0", bus.sync_err_cnt, pr_cnt - p0, merr);
        end
        bus.rx_error = 1'b1; @(negedge clk); bus.rx_error = 1'b0; @(negedge clk);
        tests++;
        if (bus.sync_err_cnt !== 8'(merr)) begin
            fails++; $display("FAIL err_idle: got err=%0d exp err=%0d", bus.sync_err_cnt, merr);
        end
        put(8'h09, 2);
        bus.rx_error = 1'b1; @(negedge clk); bus.rx_error = 1'b0;
        model_drop();
        send_pkt(8'h0A, 8'h11, 8'h22, 8'h00, 0);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp) begin fails++; $display("FAIL err_recover: got %s exp %s", show(got), show(exp)); end
    endtask

    task automatic test_enable();
        snap_t got, exp;
        do_reset();
        put(8'h08, 0); put(8'h05, 0);
        bus.enable = 1'b0;
        put(8'h00, 0); put(8'h08, 1);
        bus.enable = 1'b1;
        send_pkt(8'h0C, 8'h0A, 8'hFE, 8'h00, 0);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp) begin fails++; $display("FAIL enable_drop: got %s exp %s", show(got), show(exp)); end
    endtask

    task automatic test_back_to_back();
        snap_t got, exp;
        int p0;
        do_reset();
        p0 = pr_cnt;
        for (int i = 0; i < 5; i++) begin
            send_pkt(8'h08 | 8'(i), 8'(3 * i + 1), 8'(8'hF0 + i), 8'h00, 0);
            got = observe(); exp = expect_snap(1'b1); tests++;
            if (got !== exp) begin fails++; $display("FAIL b2b_pkt%0d: got %s exp %s", i, show(got), show(exp)); end
        end
        @(negedge clk);
        tests++;
        if (pr_cnt != p0 + 5) begin fails++; $display("FAIL b2b_count: got %0d exp %0d", pr_cnt - p0, 5); end
    endtask

    task automatic test_wheel();
        snap_t got, exp;
        int p0;
        do_reset();
        p0 = pr_cnt;
        bus.wheel_mode = 1'b1;
        send_pkt(8'h08, 8'h00, 8'h00, 8'h0F, 1);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp) begin fails++; $display("FAIL wheel_pkt: got %s exp %s", show(got), show(exp)); end
        @(negedge clk);
        tests++;
        if (pr_cnt != p0 + 1) begin fails++; $display("FAIL wheel_count: got %0d exp %0d", pr_cnt - p0, 1); end
        if (HAS_WHEEL) begin
            put(8'h09, 0);
            bus.wheel_mode = 1'b0;
            put(8'h04, 0); put(8'h02, 1);
            tests++;
            if (pr_cnt != p0 + 1) begin fails++; $display("FAIL wheel_latch_early: got %0d exp %0d", pr_cnt - p0, 1); end
            put(8'h03, 0);
            model_commit(8'h09, 8'h04, 8'h02, 8'h03, 1'b1);
            got = observe(); exp = expect_snap(1'b1); tests++;
            if (got !== exp) begin fails++; $display("FAIL wheel_latch: got %s exp %s", show(got), show(exp)); end
        end
        bus.wheel_mode = 1'b0;
        send_pkt(8'h08, 8'h01, 8'h01, 8'h00, 0);
        got = observe(); exp = expect_snap(1'b1); tests++;
        if (got !== exp) begin fails++; $display("FAIL wheel_off_dz: got %s exp %s", show(got), show(exp)); end
    endtask

    task automatic test_random();
        snap_t got, exp;
        logic [7:0] st, x, y, z;
        int gap;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3) == 0) begin
                put(8'($urandom) & 8'hF7, $urandom_range(2));
                model_drop();
            end
            bus.wheel_mode = 1'($urandom_range(1));
            st = 8'($urandom) | 8'h08;
            x  = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
            gap = ($urandom_range(3) == 0) ? T - 1 : int'($urandom_range(2));
            send_pkt(st, x, y, z, gap);
            got = observe(); exp = expect_snap(1'b1); tests++;
            if (got !== exp) begin fails++; $display("FAIL rand_pkt%0d: got %s exp %s", i, show(got), show(exp)); end
        end
        bus.wheel_mode = 1'b0;
    endtask

    task automatic test_err_saturate();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            put(8'h00, 0);
            model_drop();
        end
        tests++;
        if (bus.sync_err_cnt !== 8'(merr)) begin
            fails++; $display("FAIL err_saturate: got %0d exp %0d", bus.sync_err_cnt, merr);
        end
    endtask

    initial begin
        bus.rx_data = '0; bus.rx_ready = 1'b0; bus.rx_error = 1'b0;
        bus.enable = 1'b1; bus.wheel_mode = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_clamp();
        test_resync();
        test_timeout();
        test_error();
        test_enable();
        test_back_to_back();
        test_wheel();
        test_random();
        test_err_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_tracker.md
# ps2_mouse_tracker

Parametrised PS/2 mouse packet decoder and cursor tracker. It sits downstream of `ps2_receiver` and alongside `ps2_mouse_init` once stream mode is reached. It assembles 3-byte standard or 4-byte IntelliMouse packets from the received byte stream, recovers framing after noise, parity errors or stalls, and keeps a clamped absolute cursor position for the display pipeline.

## Interface
Parameters:
- `SCREEN_W`, default 640: horizontal range; `pos_x` is held in 0..SCREEN_W-1.
- `SCREEN_H`, default 480: vertical range; `pos_y` is held in 0..SCREEN_H-1.
- `POS_W`, default 10: width of `pos_x` and `pos_y`. Must satisfy 2^POS_W ≥ max(SCREEN_W, SCREEN_H).
- `CLK_HZ`, default 27_000_000: system clock frequency.
- `TIMEOUT_US`, default 2000: maximum gap between bytes of one packet. `TIMEOUT_CYC` = CLK_HZ/1_000_000 × TIMEOUT_US.

Ports:
- `clk`, input, 1: system clock. There is a single clock domain.
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `rx_data`, input, 8: byte from `ps2_receiver`.
- `rx_ready`, input, 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `rx_error`, input, 1: one-cycle strobe indicating a parity or framing error.
- `enable`, input, 1: tie to `init_done`. While low, all bytes are ignored and the FSM is held in S_B0.
- `wheel_mode`, input, 1: 1 selects 4-byte packets. Only effective when `PS2_WHEEL_EN` is defined.
- `pos_x`, output, POS_W: cursor X. Resets to SCREEN_W/2.
- `pos_y`, output, POS_W: cursor Y. Resets to SCREEN_H/2.
- `mouse_dx`, output, 9: signed X delta of the last packet. Resets to 0.
- `mouse_dy`, output, 9: signed Y delta of the last packet. Resets to 0.
- `wheel_dz`, output, 4: signed wheel delta of the last packet. Resets to 0.
- `buttons`, output, 3: {M,R,L} from the last packet. Resets to 0.
- `packet_ready`, output, 1: one-cycle pulse. Resets to 0.
- `sync_err_cnt`, output, 8: count of discarded packets. Saturates at 255. Resets to 0.

## Operation
- **FSM states:** S_B0, S_B1, S_B2, S_B3.
- **S_B0:**
  - A byte with bit3=1 is latched as the status byte; go to S_B1.
  - A byte with bit3=0 is dropped; `sync_err_cnt` increments and the FSM stays in S_B0. This is the resync mechanism.
- **S_B1:** latch the X byte; go to S_B2.
- **S_B2:** latch the Y byte.
  - If the packet length is 3, commit and go to S_B0.
  - Otherwise go to S_B3.
- **S_B3:** latch the wheel byte, commit, and go to S_B0.
- **Packet length:** sampled when the status byte is accepted. A `wheel_mode` change mid-packet has no effect until the next packet.
- **rx_error in any state:** discard the partial packet and go to S_B0. Increment `sync_err_cnt` only if the FSM was not in S_B0.
- **Timeout:**
  - The inter-byte counter clears on every accepted byte and runs while the FSM is not in S_B0.
  - When the counter reaches TIMEOUT_CYC−1: go to S_B0 and increment `sync_err_cnt`.
- **Delta decoding:**
  - dx = {status[4], X}; dy = {status[5], Y}. Both are 9-bit two's complement.
  - Overflow status[6] (X) or status[7] (Y) forces that axis delta to +255 or −256, chosen by its sign bit.
- **Position update:**
  - pos_x ← clamp(pos_x + dx, 0, SCREEN_W−1).
  - pos_y ← clamp(pos_y − dy, 0, SCREEN_H−1). PS/2 +Y is up; screen +Y is down.
  - Sums are computed at POS_W+2 bits signed before clamping.
- **Wheel:** `wheel_dz` = byte3[3:0]. In 3-byte mode, `wheel_dz` is 0 on every commit.

## Timing
- **Commit latency:** one cycle after the final byte's `rx_ready`.
  - `packet_ready` is high for that cycle.
  - `pos_*`, `mouse_d*`, `buttons` and `wheel_dz` change in that same cycle and are stable for at least one full cycle after it.
- **Simultaneous `rx_ready` and `rx_error`:** the error wins; the byte is dropped.
- **Simultaneous timeout and `rx_ready`:** `rx_ready` wins; the byte is accepted and the counter clears.
- **Back-to-back `rx_ready` on consecutive cycles:** must be accepted without loss.
- **Reset mid-packet:** every output returns to its reset value and the FSM returns to S_B0 on the first `clk` edge with `rst_n`=0.
- **`enable` falling mid-packet:** the packet is discarded, and `sync_err_cnt` is not incremented.

## Configuration
- **`PS2_WHEEL_EN` defined:** S_B3 and the `wheel_mode` selection are compiled in.
- **`PS2_WHEEL_EN` undefined:**
  - `wheel_mode` is ignored and every packet is 3 bytes.
  - `wheel_dz` is tied to 0.
  - S_B3 is unreachable and optimised away.

## Structure
- **Package `ps2_mouse_pkg`:**
  - FSM state encoding.
  - Status-bit index constants: BTN_L=0, BTN_R=1, BTN_M=2, ALWAYS1=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7.
  - Overflow saturation constants +255 and −256.
- **Sub-module `ps2_axis_accum`:** parameterised by range and POS_W. It holds the reset-to-centre register, the signed add/subtract, the overflow saturation and the clamp. It is instantiated twice, once for X (add) and once for Y (subtract).

## Test plan
1. Bytes 08,05,05 from reset → `packet_ready` pulses once; dx=+5, dy=+5; pos=(325,235); buttons=000.
2. Bytes 3F,F9,F9 → dx=−7, dy=−7; buttons=111; pos=(313,247).
3. Ten packets of 08,32,00 (+50 X) → `pos_x` saturates at 639 with no wrap; then a single 18,CE,00 (−50 X) gives 589.
4. Stray byte 00, then 09,0A,0A → `sync_err_cnt`=1; one packet with dx=+10; L=1.
5. Bytes 08,05, then idle for TIMEOUT_CYC+10 cycles, then 08,0A,0A → `sync_err_cnt`=1; exactly one packet, dx=+10.
6. `PS2_WHEEL_EN` defined, `wheel_mode`=1, bytes 08,00,00,0F → `wheel_dz`=−1 and a single `packet_ready`. Also, `rx_error` injected after the second byte of 08,01,01 → no packet and `sync_err_cnt`=1.
